spi_sp_ram: RTL
===============

// Module: spi_sp_ram
// PURPOSE
//  Single-port synchronous RAM with its command decoder, downstream of the SPI slave.
//  Consumes the 10-bit rx_data/rx_valid words from the slave and decodes din[9:8] as a command.
//  Commands: write address, write data, read address, read data.
//  Read data goes back to the slave on tx_data/tx_valid for serialisation onto MISO.
// PARAMETERS
//  MEM_DEPTH  256  number of 8-bit words; must be <= 2**ADDR_SIZE
//  ADDR_SIZE  8    address width; must be <= 8 (address taken from din[7:0])
//  AUTO_INC   0    1: write/read address post-increments after each data access
// PORTS
//  clk       in   1   clock, all logic on rising edge
//  rst_n     in   1   reset, synchronous, active-low
//  rx_data   in   10  command word from SPI slave: [9:8] cmd, [7:0] payload
//  rx_valid  in   1   one-cycle strobe; rx_data valid in the same cycle
//  err_clr   in   1   clears sticky err (lower priority than a new error in the same cycle)
//  tx_data   out  8   read data to SPI slave
//  tx_valid  out  1   tx_data valid; level, not pulse
//  err       out  1   sticky protocol/range error flag
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): tx_data=0, tx_valid=0, err=0.
//   wr_addr=0, rd_addr=0; wr_addr_ok=0, rd_addr_ok=0.
//   Memory contents are NOT reset. rx_valid is ignored while rst_n=0.
//   Reset mid-sequence discards any latched address.
//  Commands are acted on only in a cycle with rx_valid=1. Each high cycle is one command.
//  cmd 2'b00 WR_ADDR: wr_addr<=din[ADDR_SIZE-1:0], wr_addr_ok<=1.
//   If din[7:0]>=MEM_DEPTH: err<=1, wr_addr_ok<=0.
//  cmd 2'b01 WR_DATA: if wr_addr_ok, mem[wr_addr]<=din[7:0] at that edge.
//   Otherwise err<=1 and no write.
//   AUTO_INC=1: wr_addr<=wr_addr+1. Reaching MEM_DEPTH clears wr_addr_ok; it does not wrap.
//  cmd 2'b10 RD_ADDR: rd_addr<=din[ADDR_SIZE-1:0], rd_addr_ok<=1, tx_valid<=0.
//   Out-of-range handling is the same as WR_ADDR.
//  cmd 2'b11 RD_DATA: if rd_addr_ok, tx_data<=mem[rd_addr] and tx_valid<=1 at the same edge.
//   Latency: accepted at edge N, data visible after edge N (one clock).
//   If not rd_addr_ok: err<=1, tx_valid<=0, tx_data unchanged.
//   AUTO_INC behaves as on the write side, applied to rd_addr.
//  tx_valid: once set, stays high and tx_data stays stable until the next accepted rx_valid.
//   Any command clears it, except an RD_DATA that reloads it.
//  Read/write ordering: RD_DATA after WR_DATA to the same address returns the new data.
//   No bypass is needed; commands are at least 10 clocks apart.
//  err: set on any error above. err_clr=1 clears it unless an error occurs in that cycle.
//   Set wins over clear.
//  Write and read address registers are independent. WR_* never changes the rd_* state.
//   RD_* never changes the wr_* state.
//  The payload bits of RD_DATA (din[7:0]) are don't-care.
// STRUCTURE
//  Package spi_ram_pkg holds:
//   - localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
//   - the cmd field slice indices (9:8) and the payload width 8
//  Sub-module sp_ram_core(clk, we, waddr, wdata, re, raddr, rdata): plain synchronous array.
//   One port used per cycle; no reset.
//  The top level holds the decoder, the address registers and valid flags, the tx register and err.
// TESTING
//  1 Write/read: WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA.
//    -> tx_data=0xA5, tx_valid=1 one clk after the RD_DATA strobe; err=0.
//  2 Hold: after test 1, idle 20 clks -> tx_valid stays 1, tx_data stays 0xA5.
//    Then RD_ADDR 0x00 -> tx_valid=0 the next clk.
//  3 Protocol error: after reset, RD_DATA -> err=1, tx_valid=0.
//    Then WR_DATA 0x33 -> no memory write (read back shows old value); err stays 1.
//    err_clr pulse -> err=0.
//  4 Range (MEM_DEPTH=200): WR_ADDR 0xC8 -> err=1.
//    Following WR_DATA is rejected; WR_ADDR 0xC7 + WR_DATA 0x5A succeeds.
//  5 AUTO_INC=1: WR_ADDR 0x10, WR_DATA 1,2,3; RD_ADDR 0x10, RD_DATA x3.
//    -> tx_data sequence 1,2,3; at MEM_DEPTH-1 a second WR_DATA sets err.
//  6 Reset mid-op: WR_ADDR 0x05, then rst_n low 1 clk, then WR_DATA 0x77.
//    -> err=1, no write; tx_valid=0 and err=0 during reset.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - command encodings and field layout for the SPI RAM decoder
package spi_ram_pkg;

  localparam int RX_W      = 10;
  localparam int CMD_HI    = 9;
  localparam int CMD_LO    = 8;
  localparam int PAYLOAD_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/sp_ram_core.sv
// rtl/sp_ram_core.sv - plain synchronous single-port array, no reset
module sp_ram_core #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Registered write and registered read; the caller never asserts both in one cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_sp_ram.sv
// rtl/spi_sp_ram.sv - command decoder, address registers and read-back path for the SPI RAM
module spi_sp_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RX_W-1:0]      rx_data,
  input  logic                 rx_valid,
  input  logic                 err_clr,
  output logic [PAYLOAD_W-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 err
);

  localparam logic [8:0]         DEPTH_P = 9'(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] DEPTH_A = (ADDR_SIZE+1)'(MEM_DEPTH);

  logic [1:0]           cmd;
  logic [PAYLOAD_W-1:0] payload;
  logic                 accept, out_of_range;
  logic                 do_write, do_read, cmd_err;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic [ADDR_SIZE:0]   wr_next, rd_next;
  logic                 wr_addr_ok, rd_addr_ok;
  logic                 tx_loaded;
  logic [PAYLOAD_W-1:0] ram_rdata;

  assign cmd     = rx_data[CMD_HI:CMD_LO];
  assign payload = rx_data[PAYLOAD_W-1:0];

  // Decode one strobed command; strobes during reset are dropped here so they never reach the array.
  always_comb begin
    accept       = rx_valid & rst_n;
    out_of_range = ({1'b0, payload} >= DEPTH_P);
    do_write     = accept && (cmd == CMD_WR_DATA) && wr_addr_ok;
    do_read      = accept && (cmd == CMD_RD_DATA) && rd_addr_ok;
    wr_next      = {1'b0, wr_addr} + 1'b1;
    rd_next      = {1'b0, rd_addr} + 1'b1;
    cmd_err      = 1'b0;
    if (accept) begin
      case (cmd)
        CMD_WR_ADDR: cmd_err = out_of_range;
        CMD_WR_DATA: cmd_err = !wr_addr_ok;
        CMD_RD_ADDR: cmd_err = out_of_range;
        default:     cmd_err = !rd_addr_ok;
      endcase
    end
  end

  // Address registers, valid flags, tx level and sticky error; the counters stop at the end rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_addr_ok <= 1'b0;
      rd_addr_ok <= 1'b0;
      tx_valid   <= 1'b0;
      tx_loaded  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (cmd_err) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (accept) begin
        tx_valid <= 1'b0;
        case (cmd)
          CMD_WR_ADDR: begin
            wr_addr    <= payload[ADDR_SIZE-1:0];
            wr_addr_ok <= !out_of_range;
          end
          CMD_WR_DATA: begin
            if (wr_addr_ok && AUTO_INC) begin
              wr_addr <= wr_next[ADDR_SIZE-1:0];
              if (wr_next == DEPTH_A) wr_addr_ok <= 1'b0;
            end
          end
          CMD_RD_ADDR: begin
            rd_addr    <= payload[ADDR_SIZE-1:0];
            rd_addr_ok <= !out_of_range;
          end
          default: begin
            if (rd_addr_ok) begin
              tx_valid  <= 1'b1;
              tx_loaded <= 1'b1;
              if (AUTO_INC) begin
                rd_addr <= rd_next[ADDR_SIZE-1:0];
                if (rd_next == DEPTH_A) rd_addr_ok <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  // The array's read register is the tx holding register; it only changes on an accepted read.
  assign tx_data = tx_loaded ? ram_rdata : '0;

  sp_ram_core #(
    .DEPTH(MEM_DEPTH),
    .AW   (ADDR_SIZE),
    .DW   (PAYLOAD_W)
  ) u_core (
    .clk  (clk),
    .we   (do_write),
    .waddr(wr_addr),
    .wdata(payload),
    .re   (do_read),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

endmodule
